// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   ADDR_W / INSTR_W  : PC and instruction-word widths
//   HALT_OPCODE       : opcode value (instr[OPC_MSB:OPC_LSB]) that stops fetching
//   fetch_entry_t     : one prefetch-buffer slot, {instr, pc}
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam int          OPC_MSB     = 15;
  localparam int          OPC_LSB     = 12;
  localparam logic [3:0]  HALT_OPCODE = 4'hF;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch stage: instruction-memory read port,
// branch redirect from execute and the fetch->decode handshake.
//   master : the fetch unit
//   slave  : its environment (memory, execute, decode)
//
// Fetch->decode handshake: fetch_valid/fetch_instr/fetch_pc are driven from
// state only; a transfer happens on a posedge where fetch_valid && decode_ready.
// While fetch_valid && !decode_ready the payload holds stable. When
// fetch_valid is low the payload is zero.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  program_counter;
  logic [INSTR_W-1:0] instruction;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               decode_ready;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr;
  logic [ADDR_W-1:0]  fetch_pc;
  logic               halted;

  modport master (
    output program_counter, fetch_valid, fetch_instr, fetch_pc, halted,
    input  instruction, branch_taken, branch_target, decode_ready
  );

  modport slave (
    input  program_counter, fetch_valid, fetch_instr, fetch_pc, halted,
    output instruction, branch_taken, branch_target, decode_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO of fetch entries.
//   clock, reset : clock and synchronous active-high reset
//   flush        : empty the FIFO (wins over push/pop)
//   push/wr_entry: write at tail; accepted when not full or when popping
//   pop          : remove head (ignored when empty)
//   rd_entry     : head entry, zero when empty
//   count        : number of occupied entries
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     wr_entry,
  input  logic             pop,
  output fetch_entry_t     rd_entry,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
      if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) mem[tail_ptr] <= wr_entry;
  end

  assign rd_entry = (count != '0) ? mem[head_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC (driven straight from a register as
// the instruction-memory address), pushes {instruction, pc} into a 2-entry
// prefetch buffer and serves decode over a valid/ready handshake.
//   clock, reset : clock and synchronous active-high reset
//   bus (master) : memory read port, branch redirect, decode handshake, halted
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] pc_q;
  logic              halted_q;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      new_entry;
  logic              deq;
  logic              enq;

  assign bus.fetch_valid = (count != '0);
  assign deq = bus.fetch_valid && bus.decode_ready;
  // A redirect suppresses enqueue: the word at the old PC is on the wrong path.
  assign enq = !halted_q && !bus.branch_taken && ((count < CNT_W'(DEPTH)) || deq);

  assign new_entry.instr = bus.instruction;
  assign new_entry.pc    = pc_q;

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clock    (clock),
    .reset    (reset),
    .flush    (bus.branch_taken),
    .push     (enq),
    .wr_entry (new_entry),
    .pop      (deq),
    .rd_entry (head),
    .count    (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else if (bus.branch_taken) begin
      // Redirect also cancels a HALT that was fetched down the wrong path.
      pc_q     <= bus.branch_target;
      halted_q <= 1'b0;
    end else if (enq) begin
      pc_q <= pc_q + ADDR_W'(1);
      if (is_halt(bus.instruction)) halted_q <= 1'b1;
    end
  end

  assign bus.program_counter = pc_q;
  assign bus.halted          = halted_q;
  assign bus.fetch_instr     = head.instr;
  assign bus.fetch_pc        = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a combinational instruction-memory model,
// a scoreboard queue of expected {pc, instr} deliveries and a monitor that
// compares every accepted transfer.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clock;
  logic reset;
  fetch_unit_if bus ();

  logic [INSTR_W-1:0] mem [256];
  logic [ADDR_W+INSTR_W-1:0] exp_q [$];
  int n_compared;
  int n_mismatched;

  fetch_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.instruction = mem[bus.program_counter];

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [ADDR_W-1:0] pc, input logic [INSTR_W-1:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset && bus.fetch_valid && bus.decode_ready) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL unexpected_delivery: got pc=%h instr=%h expected none",
                 bus.fetch_pc, bus.fetch_instr);
      end else begin
        logic [ADDR_W+INSTR_W-1:0] e;
        e = exp_q.pop_front();
        if ({bus.fetch_pc, bus.fetch_instr} !== e) begin
          n_mismatched++;
          $display("FAIL delivery: got pc=%h instr=%h expected pc=%h instr=%h",
                   bus.fetch_pc, bus.fetch_instr, e[ADDR_W+INSTR_W-1:INSTR_W], e[INSTR_W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'h1004;
    mem[4] = 16'h1005; mem[5] = 16'hF000;
    mem[8'h40] = 16'h4040; mem[8'h41] = 16'h4041; mem[8'h42] = 16'h4042;
    mem[8'h10] = 16'h5010; mem[8'h11] = 16'h5011; mem[8'h12] = 16'h5012;
    mem[8'hFE] = 16'h70FE; mem[8'hFF] = 16'h70FF;

    reset = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.decode_ready  = 1'b0;
    tick(); tick();
    check("reset_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("reset_fetch_instr", 32'(bus.fetch_instr), 32'd0);
    check("reset_fetch_pc",    32'(bus.fetch_pc), 32'd0);
    check("reset_pc",          32'(bus.program_counter), 32'd0);
    check("reset_halted",      32'(bus.halted), 32'd0);

    // Run: 4 instructions streamed back to back.
    expect_fetch(8'd0, 16'h1001); expect_fetch(8'd1, 16'h1002);
    expect_fetch(8'd2, 16'h1003); expect_fetch(8'd3, 16'h1004);
    reset = 1'b0;
    bus.decode_ready = 1'b1;
    tick();
    check("run_first_valid", 32'(bus.fetch_valid), 32'd1);
    check("run_first_pc",    32'(bus.fetch_pc), 32'd0);
    tick(); tick(); tick(); tick();
    bus.decode_ready = 1'b0;
    reset = 1'b1;
    tick();
    check("rst1_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst1_pc",          32'(bus.program_counter), 32'd0);

    // Back-pressure: buffer fills to 2, head holds.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("bp_instr_hold", 32'(bus.fetch_instr), 32'h1001);
    check("bp_pc_hold",    32'(bus.fetch_pc), 32'd0);
    check("bp_pc_stop",    32'(bus.program_counter), 32'd2);
    check("bp_valid",      32'(bus.fetch_valid), 32'd1);
    expect_fetch(8'd0, 16'h1001); expect_fetch(8'd1, 16'h1002); expect_fetch(8'd2, 16'h1003);
    bus.decode_ready = 1'b1;
    tick(); tick(); tick();
    bus.decode_ready = 1'b0;

    // Branch with 2 entries buffered (pc 3, 4): both discarded.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h40;
    tick();
    bus.branch_taken = 1'b0;
    check("br_flush_valid", 32'(bus.fetch_valid), 32'd0);
    check("br_flush_instr", 32'(bus.fetch_instr), 32'd0);
    check("br_pc",          32'(bus.program_counter), 32'h40);
    tick();
    check("br_target_valid", 32'(bus.fetch_valid), 32'd1);
    check("br_target_pc",    32'(bus.fetch_pc), 32'h40);
    check("br_target_instr", 32'(bus.fetch_instr), 32'h4040);
    expect_fetch(8'h40, 16'h4040); expect_fetch(8'h41, 16'h4041);
    bus.decode_ready = 1'b1;
    tick(); tick();

    // HALT at address 5.
    bus.decode_ready  = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h04;
    tick();
    bus.branch_taken = 1'b0;
    expect_fetch(8'h04, 16'h1005); expect_fetch(8'h05, 16'hF000);
    bus.decode_ready = 1'b1;
    tick(); tick();
    check("halt_flag",     32'(bus.halted), 32'd1);
    check("halt_pc_frz",   32'(bus.program_counter), 32'd6);
    check("halt_head_pc",  32'(bus.fetch_pc), 32'd5);
    tick();
    check("halt_drained",  32'(bus.fetch_valid), 32'd0);
    tick(); tick();
    check("halt_still_pc",    32'(bus.program_counter), 32'd6);
    check("halt_still_valid", 32'(bus.fetch_valid), 32'd0);
    check("halt_still_flag",  32'(bus.halted), 32'd1);

    // Redirect cancels halt.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h10;
    tick();
    bus.branch_taken = 1'b0;
    check("unhalt_flag", 32'(bus.halted), 32'd0);
    check("unhalt_pc",   32'(bus.program_counter), 32'h10);
    expect_fetch(8'h10, 16'h5010); expect_fetch(8'h11, 16'h5011);
    tick(); tick(); tick();

    // Wrap through 0xFF -> 0x00.
    bus.decode_ready  = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'hFE;
    tick();
    bus.branch_taken = 1'b0;
    expect_fetch(8'hFE, 16'h70FE); expect_fetch(8'hFF, 16'h70FF); expect_fetch(8'h00, 16'h1001);
    bus.decode_ready = 1'b1;
    tick(); tick(); tick(); tick();
    bus.decode_ready = 1'b0;
    tick();
    check("wrap_head_pc", 32'(bus.fetch_pc), 32'd1);
    check("wrap_pc",      32'(bus.program_counter), 32'd3);

    // Reset with 2 entries buffered.
    reset = 1'b1;
    tick();
    check("rst2_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    check("rst2_pc",          32'(bus.program_counter), 32'd0);
    check("rst2_fetch_pc",    32'(bus.fetch_pc), 32'd0);
    reset = 1'b0;
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
